// File: rtl/duck_sprite_renderer.sv
// Pixel stage for one bouncing duck: frame-tick motion, trigger hit test, hit/fall/respawn FSM.
// Optional DUCK_DEBUG_BOX_EN draws a red 1-pixel outline around the duck box in every state.
module duck_sprite_renderer #(
  parameter int SPRITE_W   = 32,
  parameter int SPRITE_H   = 32,
  parameter int SPEED      = 2,
  parameter int FALL_SPEED = 4,
  parameter int GROUND_Y   = 400,
  parameter int START_X    = 100,
  parameter int START_Y    = 200,
  parameter int HIT_FRAMES = 30
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_col_count,
  input  logic [9:0] i_row_count,
  input  logic       i_valid,
  input  logic [9:0] i_aim_x,
  input  logic [9:0] i_aim_y,
  input  logic       i_shoot,
  output logic [5:0] o_rgb,
  output logic       o_duck_hit,
  output logic [1:0] o_state
);

  localparam logic [1:0] ST_FLY     = 2'd0;
  localparam logic [1:0] ST_HIT     = 2'd1;
  localparam logic [1:0] ST_FALL    = 2'd2;
  localparam logic [1:0] ST_RESPAWN = 2'd3;

  localparam int CNT_W = $clog2(HIT_FRAMES + 1);

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);
  localparam logic signed [10:0] FALL_S  = 11'(FALL_SPEED);
  localparam logic signed [10:0] X_MAX   = 11'(640 - SPRITE_W);
  localparam logic signed [10:0] Y_MAX   = 11'(GROUND_Y - SPRITE_H);

  localparam logic [5:0] RGB_BLACK  = 6'b000000;
  localparam logic [5:0] RGB_DUCK   = 6'b100100;
  localparam logic [5:0] RGB_HITDK  = 6'b111111;
  localparam logic [5:0] RGB_GROUND = 6'b001000;
  localparam logic [5:0] RGB_SKY    = 6'b000111;

  logic [9:0]       r_x;
  logic [9:0]       r_y;
  logic             r_dx_pos;
  logic             r_dy_pos;
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [5:0]       r_rgb;
  logic             r_duck_hit;

  logic             w_frame_tick;
  logic [10:0]      w_x_end;
  logic [10:0]      w_y_end;
  logic             w_pix_in_box;
  logic             w_aim_in_box;
  logic             w_hit;
  logic signed [10:0] w_nx;
  logic signed [10:0] w_ny;
  logic signed [10:0] w_fall_ny;
  logic [9:0]       w_fly_x;
  logic [9:0]       w_fly_y;
  logic             w_fly_dx_pos;
  logic             w_fly_dy_pos;
  logic [5:0]       w_rgb_next;

  assign w_frame_tick = (i_row_count == 10'd480) && (i_col_count == 10'd0);

  assign w_x_end = {1'b0, r_x} + 11'(SPRITE_W);
  assign w_y_end = {1'b0, r_y} + 11'(SPRITE_H);

  assign w_pix_in_box = ({1'b0, i_col_count} >= {1'b0, r_x}) && ({1'b0, i_col_count} < w_x_end) &&
                        ({1'b0, i_row_count} >= {1'b0, r_y}) && ({1'b0, i_row_count} < w_y_end);

  // Hit test always uses the current (pre-move) box, even on a frame tick.
  assign w_aim_in_box = ({1'b0, i_aim_x} >= {1'b0, r_x}) && ({1'b0, i_aim_x} < w_x_end) &&
                        ({1'b0, i_aim_y} >= {1'b0, r_y}) && ({1'b0, i_aim_y} < w_y_end);

  assign w_hit = i_shoot && (r_state == ST_FLY) && w_aim_in_box;

  assign w_nx      = $signed({1'b0, r_x}) + (r_dx_pos ? SPEED_S : -SPEED_S);
  assign w_ny      = $signed({1'b0, r_y}) + (r_dy_pos ? SPEED_S : -SPEED_S);
  assign w_fall_ny = $signed({1'b0, r_y}) + FALL_S;

  // Bounce: clamp to the wall that was reached and reverse that axis.
  always_comb begin
    w_fly_x      = w_nx[9:0];
    w_fly_dx_pos = r_dx_pos;
    if (w_nx <= 11'sd0) begin
      w_fly_x      = 10'd0;
      w_fly_dx_pos = ~r_dx_pos;
    end else if (w_nx >= X_MAX) begin
      w_fly_x      = X_MAX[9:0];
      w_fly_dx_pos = ~r_dx_pos;
    end

    w_fly_y      = w_ny[9:0];
    w_fly_dy_pos = r_dy_pos;
    if (w_ny <= 11'sd0) begin
      w_fly_y      = 10'd0;
      w_fly_dy_pos = ~r_dy_pos;
    end else if (w_ny >= Y_MAX) begin
      w_fly_y      = Y_MAX[9:0];
      w_fly_dy_pos = ~r_dy_pos;
    end
  end

`ifdef DUCK_DEBUG_BOX_EN
  logic w_pix_on_edge;
  assign w_pix_on_edge = ({1'b0, i_col_count} == {1'b0, r_x}) ||
                         ({1'b0, i_col_count} == (w_x_end - 11'd1)) ||
                         ({1'b0, i_row_count} == {1'b0, r_y}) ||
                         ({1'b0, i_row_count} == (w_y_end - 11'd1));
`endif

  always_comb begin
    w_rgb_next = RGB_SKY;
    if (!i_valid) begin
      w_rgb_next = RGB_BLACK;
    end
`ifdef DUCK_DEBUG_BOX_EN
    else if (w_pix_in_box && w_pix_on_edge) begin
      w_rgb_next = 6'b110000;
    end
`endif
    else if (w_pix_in_box && (r_state != ST_RESPAWN)) begin
      w_rgb_next = (r_state == ST_HIT) ? RGB_HITDK : RGB_DUCK;
    end else if (i_row_count >= 10'(GROUND_Y)) begin
      w_rgb_next = RGB_GROUND;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_x        <= 10'(START_X);
      r_y        <= 10'(START_Y);
      r_dx_pos   <= 1'b1;
      r_dy_pos   <= 1'b0;
      r_state    <= ST_FLY;
      r_hit_cnt  <= '0;
      r_rgb      <= RGB_BLACK;
      r_duck_hit <= 1'b0;
    end else begin
      r_rgb      <= w_rgb_next;
      r_duck_hit <= 1'b0;
      // A hit takes priority over that frame's motion.
      if (w_hit) begin
        r_state    <= ST_HIT;
        r_hit_cnt  <= '0;
        r_duck_hit <= 1'b1;
      end else if (w_frame_tick) begin
        case (r_state)
          ST_FLY: begin
            r_x      <= w_fly_x;
            r_y      <= w_fly_y;
            r_dx_pos <= w_fly_dx_pos;
            r_dy_pos <= w_fly_dy_pos;
          end
          ST_HIT: begin
            if (r_hit_cnt == CNT_W'(HIT_FRAMES - 1)) begin
              r_state <= ST_FALL;
            end else begin
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end
          ST_FALL: begin
            if (w_fall_ny >= Y_MAX) begin
              r_y     <= Y_MAX[9:0];
              r_state <= ST_RESPAWN;
            end else begin
              r_y <= w_fall_ny[9:0];
            end
          end
          default: begin
            r_x      <= 10'(START_X);
            r_y      <= 10'(START_Y);
            r_dy_pos <= 1'b0;
            r_dx_pos <= ~r_dx_pos;
            r_state  <= ST_FLY;
          end
        endcase
      end
    end
  end

  assign o_rgb      = r_rgb;
  assign o_duck_hit = r_duck_hit;
  assign o_state    = r_state;

endmodule
